alu_wb_buffer: RTL and testbench

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

---
 rtl/alu_wb_buffer.sv | 96 +++++++++
 tb/tb_alu_wb_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - FIFO write-back buffer for ALU results with condition evaluation
// Buffers {opcode, result, flags} and tracks a sticky overflow indication.
module alu_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [5:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_opcode,
  output logic [WIDTH-1:0]         out_result,
  output logic [5:0]               out_flags,
  input  logic [2:0]               cond,
  output logic                     cond_true,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]       opcode_mem [DEPTH];
  logic [WIDTH-1:0] result_mem [DEPTH];
  logic [5:0]       flags_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Both handshakes derive only from registered count, so there is no ready/valid loop.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      opcode_mem[wr_ptr] <= in_opcode;
      result_mem[wr_ptr] <= in_result;
      flags_mem[wr_ptr]  <= in_flags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow takes priority over a clear in the same cycle.
      if (push && in_flags[5])
        sticky_ovf <= 1'b1;
      else if (clr_sticky)
        sticky_ovf <= 1'b0;
    end
  end

  assign out_opcode = opcode_mem[rd_ptr];
  assign out_result = result_mem[rd_ptr];
  assign out_flags  = flags_mem[rd_ptr];

  // flags: {overflow, negative, zero, equal, greater, less}
  always_comb begin
    cond_true = 1'b0;
    if (out_valid) begin
      case (cond)
        3'd1:    cond_true = out_flags[2];
        3'd2:    cond_true = ~out_flags[2];
        3'd3:    cond_true = out_flags[0];
        3'd4:    cond_true = ~out_flags[0];
        3'd5:    cond_true = out_flags[1];
        3'd6:    cond_true = ~out_flags[1];
        3'd7:    cond_true = out_flags[5];
        default: cond_true = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - directed self-checking bench for alu_wb_buffer
// Inputs change on the falling edge or 1 time unit after the rising edge.
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = 3'd0;
  logic [63:0] in_result = 64'd0;
  logic [5:0]  in_flags = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_opcode;
  logic [63:0] out_result;
  logic [5:0]  out_flags;
  logic [2:0]  cond = 3'd0;
  logic        cond_true;
  logic        sticky_ovf;
  logic        clr_sticky = 1'b0;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail = 0;

  alu_wb_buffer #(.DEPTH(2), .WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_result(out_result), .out_flags(out_flags),
    .cond(cond), .cond_true(cond_true),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .count(count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [2:0] op, input logic [63:0] res, input logic [5:0] fl);
    @(negedge clk);
    in_valid  = 1'b1;
    in_opcode = op;
    in_result = res;
    in_flags  = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cond  = 3'd2;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", sticky_ovf); end
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL reset_cond_true got %b want 0", cond_true); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    push(3'd1, 64'd37, 6'b000001);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    n_checks++; if (out_result !== 64'd37) begin n_fail++; $display("FAIL basic_result got %0d want 37", out_result); end
    n_checks++; if (out_opcode !== 3'd1) begin n_fail++; $display("FAIL basic_opcode got %0d want 1", out_opcode); end
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", count); end
    cond = 3'd3; #1;
    n_checks++; if (cond_true !== 1'b1) begin n_fail++; $display("FAIL basic_cond_less got %b want 1", cond_true); end
    cond = 3'd1; #1;
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL basic_cond_equal got %b want 0", cond_true); end
    cond = 3'd4; #1;
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL basic_cond_notless got %b want 0", cond_true); end
    pop();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid got %b want 0", out_valid); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL basic_drain_count got %0d want 0", count); end
  endtask

  task automatic test_flags();
    push(3'd2, 64'd0, 6'b001100);
    cond = 3'd1; #1;
    n_checks++; if (cond_true !== 1'b1) begin n_fail++; $display("FAIL flags_cond_equal got %b want 1", cond_true); end
    cond = 3'd2; #1;
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL flags_cond_notequal got %b want 0", cond_true); end
    cond = 3'd5; #1;
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL flags_cond_greater got %b want 0", cond_true); end
    cond = 3'd6; #1;
    n_checks++; if (cond_true !== 1'b1) begin n_fail++; $display("FAIL flags_cond_notgreater got %b want 1", cond_true); end
    cond = 3'd0; #1;
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL flags_cond_zero got %b want 0", cond_true); end
    n_checks++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL flags_sticky got %b want 0", sticky_ovf); end
    n_checks++; if (out_flags !== 6'b001100) begin n_fail++; $display("FAIL flags_out_flags got %b want 001100", out_flags); end
    pop();
  endtask

  task automatic test_sticky();
    push(3'd1, 64'h8000_0000_0000_0002, 6'b110000);
    n_checks++; if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL sticky_set got %b want 1", sticky_ovf); end
    n_checks++; if (out_result !== 64'h8000_0000_0000_0002) begin n_fail++; $display("FAIL sticky_result got %h want 8000000000000002", out_result); end
    cond = 3'd7; #1;
    n_checks++; if (cond_true !== 1'b1) begin n_fail++; $display("FAIL sticky_cond_ovf got %b want 1", cond_true); end
    pop();
    n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL sticky_cond_empty got %b want 0", cond_true); end
    n_checks++; if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL sticky_hold got %b want 1", sticky_ovf); end
    @(negedge clk); clr_sticky = 1'b1;
    @(posedge clk); #1; clr_sticky = 1'b0;
    n_checks++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL sticky_clear got %b want 0", sticky_ovf); end
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 3'd6; in_result = 64'd0; in_flags = 6'b100000; clr_sticky = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; clr_sticky = 1'b0;
    n_checks++; if (sticky_ovf !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins got %b want 1", sticky_ovf); end
    pop();
    @(negedge clk); clr_sticky = 1'b1;
    @(posedge clk); #1; clr_sticky = 1'b0;
    n_checks++; if (sticky_ovf !== 1'b0) begin n_fail++; $display("FAIL sticky_clear2 got %b want 0", sticky_ovf); end
    cond = 3'd0;
  endtask

  task automatic test_full();
    push(3'd0, 64'd12, 6'b000000);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1 got %b want 1", in_ready); end
    push(3'd0, 64'd25, 6'b000000);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready2 got %b want 0", in_ready); end
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_count got %0d want 2", count); end
    @(negedge clk); in_valid = 1'b1; in_result = 64'd99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_result !== 64'd12) begin n_fail++; $display("FAIL full_hold_result cycle %0d got %0d want 12", i, out_result); end
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL full_hold_count cycle %0d got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    n_checks++; if (out_result !== 64'd12) begin n_fail++; $display("FAIL full_drain_first got %0d want 12", out_result); end
    @(posedge clk); #1;
    n_checks++; if (out_result !== 64'd25 || count !== 2'd1) begin n_fail++; $display("FAIL full_drain_second got %0d/%0d want 25/1", out_result, count); end
    @(posedge clk); #1; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL full_drain_empty got %b/%0d want 0/0", out_valid, count); end
    push(3'd0, 64'd40, 6'b000000);
    push(3'd0, 64'd41, 6'b000000);
    @(negedge clk); in_valid = 1'b1; in_result = 64'd77; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_checks++; if (count !== 2'd1 || out_result !== 64'd41) begin n_fail++; $display("FAIL full_pop_refuse got %0d/%0d want 1/41", count, out_result); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got %b want 1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    n_checks++; if (count !== 2'd2 || out_result !== 64'd41) begin n_fail++; $display("FAIL full_refill got %0d/%0d want 2/41", count, out_result); end
    pop();
    n_checks++; if (out_result !== 64'd77 || count !== 2'd1) begin n_fail++; $display("FAIL full_wrap_head got %0d/%0d want 77/1", out_result, count); end
    pop();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_wrap_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int next_exp = 1;
    int received = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        in_valid  = 1'b1;
        in_opcode = 3'd6;
        in_result = 64'(cyc + 1);
        in_flags  = 6'b000000;
      end else begin
        in_valid = 1'b0;
      end
      if (count > 2'd1) begin n_fail++; $display("FAIL b2b_count cycle %0d got %0d want <=1", cyc, count); end
      if (out_valid) begin
        n_checks++; if (out_result !== 64'(next_exp)) begin n_fail++; $display("FAIL b2b_order got %0d want %0d", out_result, next_exp); end
        next_exp++;
        received++;
      end
    end
    out_ready = 1'b0;
    n_checks++; if (received !== 8) begin n_fail++; $display("FAIL b2b_delivered got %0d want 8", received); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_final_count got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    push(3'd1, 64'd3, 6'b000000);
    push(3'd1, 64'd4, 6'b000000);
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre_count got %0d want 2", count); end
    @(negedge clk); #2;
    reset = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL rstmid_async got %b/%0d want 0/0", out_valid, count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    @(negedge clk); reset = 1'b0;
    push(3'd0, 64'd5, 6'b000000);
    n_checks++; if (out_valid !== 1'b1 || out_result !== 64'd5 || count !== 2'd1) begin n_fail++; $display("FAIL rstmid_push got %b/%0d/%0d want 1/5/1", out_valid, out_result, count); end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_sticky();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
